// File: rtl/ser2par_pkg.sv
// Shared constants and helpers for the serial-to-parallel collector.
// Build option: define SER2PAR_PINGPONG_EN for two banks; otherwise a single bank.
package ser2par_pkg;

`ifdef SER2PAR_PINGPONG_EN
    localparam int unsigned NBANKS = 2;
`else
    localparam int unsigned NBANKS = 1;
`endif

    // Lane index width; at least one bit so the index register always exists.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Bit offset of a lane inside the flat packed vector.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/ser2par_bank.sv
// One N x DW sample bank: lane-addressed write port, flat packed read port.
module ser2par_bank
    import ser2par_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 8,
    parameter int unsigned IW = 3
) (
    input  logic            CLK,
    input  logic            we_i,
    input  logic [IW-1:0]   lane_i,
    input  logic [DW-1:0]   dat_i,
    output logic [N*DW-1:0] rd_o
);

    logic [N*DW-1:0] mem_q;

    // Sample storage; contents carry no reset value.
    always_ff @(posedge CLK) begin
        for (int unsigned k = 0; k < N; k++) begin
            if (we_i && (lane_i == IW'(k))) begin
                mem_q[lane_lsb(k, DW) +: DW] <= dat_i;
            end
        end
    end

    assign rd_o = mem_q;

endmodule

// File: rtl/ser2par_buf.sv
// Serial-to-parallel collector with optional ping-pong banking.
// Build option: SER2PAR_PINGPONG_EN selects two banks; undefined uses one bank.
module ser2par_buf
    import ser2par_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            STBi,
    input  logic [DW-1:0]   DATi,
    input  logic            SOFi,
    output logic            ACKi,
    output logic            STBo,
    output logic [N*DW-1:0] DATo,
    input  logic            ACKo,
    output logic            SYNC_ERRo
);

    localparam int unsigned IW       = idx_width(N);
    localparam logic [IW-1:0] LAST   = IW'(N - 1);
    localparam bit            PINGPONG = (NBANKS == 2);

    logic [IW-1:0] idx_q, idx_d;
    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [1:0]    full_q, full_d;
    logic          stb_q, stb_d;
    logic          err_q, err_d;

    logic          ack_in_c;
    logic          drain_c;
    logic [IW-1:0] wr_lane_c;

    // Bookkeeping registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q  <= '0;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            full_q <= '0;
            stb_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            full_q <= full_d;
            stb_q  <= stb_d;
            err_q  <= err_d;
        end
    end

    // Fill and drain control; a fill and a drain of different banks apply together.
    always_comb begin
        idx_d     = idx_q;
        wb_d      = wb_q;
        rb_d      = rb_q;
        full_d    = full_q;
        err_d     = err_q;
        wr_lane_c = idx_q;
        ack_in_c  = STBi & ~full_q[wb_q];
        drain_c   = stb_q & ACKo;

        if (drain_c) begin
            full_d[rb_q] = 1'b0;
            if (PINGPONG) begin
                rb_d = ~rb_q;
            end
        end

        if (ack_in_c) begin
            if (SOFi) begin
                wr_lane_c = '0;
                idx_d     = IW'(1);
                if (idx_q != '0) begin
                    err_d = 1'b1;
                end
            end else if (idx_q == LAST) begin
                idx_d        = '0;
                full_d[wb_q] = 1'b1;
                if (PINGPONG) begin
                    wb_d = ~wb_q;
                end
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end

        stb_d = full_d[rb_d];
    end

    assign ACKi      = ack_in_c;
    assign STBo      = stb_q;
    assign SYNC_ERRo = err_q;

`ifdef SER2PAR_PINGPONG_EN
    logic [N*DW-1:0] rd0, rd1;

    ser2par_bank #(.DW(DW), .N(N), .IW(IW)) u_bank0 (
        .CLK    (CLK),
        .we_i   (ack_in_c & ~wb_q),
        .lane_i (wr_lane_c),
        .dat_i  (DATi),
        .rd_o   (rd0)
    );

    ser2par_bank #(.DW(DW), .N(N), .IW(IW)) u_bank1 (
        .CLK    (CLK),
        .we_i   (ack_in_c & wb_q),
        .lane_i (wr_lane_c),
        .dat_i  (DATi),
        .rd_o   (rd1)
    );

    assign DATo = rb_q ? rd1 : rd0;
`else
    logic [N*DW-1:0] rd0;

    ser2par_bank #(.DW(DW), .N(N), .IW(IW)) u_bank0 (
        .CLK    (CLK),
        .we_i   (ack_in_c),
        .lane_i (wr_lane_c),
        .dat_i  (DATi),
        .rd_o   (rd0)
    );

    assign DATo = rd0;
`endif

endmodule

// File: doc/ser2par_buf.md
# ser2par_buf

Parametrised serial-to-parallel collector with ping-pong buffering. It sits in front of the 1-D DCT stage: it accepts one DW-bit sample per handshake and assembles N samples into a parallel vector. It then presents the vector to the transform with a strobe/acknowledge handshake. Two banks let the next vector fill while the previous one waits for the consumer, so a timely consumer sees one sample per cycle end to end.

## Interface
- DW, 8, sample width in bits
- N, 8, samples per vector (lanes), N >= 2
- IW, $clog2(N), lane index width (derived, not overridden)
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- STBi  in  1  input sample valid
- DATi  in  DW  input sample
- SOFi  in  1  start-of-vector marker, qualified by STBi
- ACKi  out  1  input sample accepted this cycle (combinational)
- STBo  out  1  output vector valid (registered)
- DATo  out  N*DW  output vector; lane k at bits [k*DW +: DW]; lane 0 is the first sample received
- ACKo  in  1  consumer takes the vector
- SYNC_ERRo  out  1  sticky: SOFi arrived with a partial vector pending

## Operation
- State:
  - two banks B0/B1 of N x DW
  - write-bank pointer wb
  - read-bank pointer rb
  - per-bank full flags F[1:0]
  - lane index idx (0..N-1)
- ACKi = STBi & ~F[wb]. Data is not reset.
- On ACKi:
  - Write Bwb[idx] <= DATi.
  - If idx == N-1: idx <= 0, F[wb] <= 1, wb toggles.
  - Otherwise idx <= idx+1.
- SOFi resync on ACKi & SOFi:
  - The sample is written to lane 0 and idx <= 1.
  - If idx != 0 beforehand, the partial vector is discarded and SYNC_ERRo <= 1.
  - SYNC_ERRo is cleared only by RST.
  - If N == 1 behaviour is undefined (excluded by parameter rule).
- STBo = F[rb], held in a register copy. DATo = Brb.
- On STBo & ACKo: F[rb] <= 0, rb toggles.
- Simultaneous fill of one bank and drain of the other in the same cycle are both applied.
- Same-bank set and clear in one cycle is impossible, because a write requires ~F[wb].
- Both banks full: ACKi = 0 and STBi is stalled. Producer must hold STBi/DATi/SOFi stable until ACKi.
- ACKo with STBo = 0 is ignored.
- DATo is stable while STBo = 1 and changes only after the accepting edge.

## Timing
- Reset values:
  - STBo = 0, SYNC_ERRo = 0
  - ACKi = STBi (both banks empty)
  - idx = 0, wb = rb = 0, F = 0
  - DATo contents undefined
- RST mid-vector discards all partial and full vectors. Vectors not yet ACKo'd are lost.
- Latency: last sample accepted at edge t, so STBo = 1 from cycle t+1.
- Input throughput: 1 sample/cycle indefinitely if the consumer asserts ACKo within N cycles of STBo.
- Zero input bubbles at vector boundaries: a sample can be accepted in the same cycle the previous vector completes.

## Configuration
- SER2PAR_PINGPONG_EN defined: two banks as above.
- Not defined: single bank only (wb = rb = 0 fixed) with the same port list.
  - ACKi = STBi & ~F[0].
  - After the last sample, input stalls until STBo & ACKo.
  - First sample of the next vector is accepted no earlier than the cycle after the accepting ACKo edge.
- SOFi and SYNC_ERRo behave identically in both builds.

## Structure
- Package ser2par_pkg:
  - lane index width function
  - bank count constant derived from SER2PAR_PINGPONG_EN
  - lane slice helper for DATo packing
- Sub-module ser2par_bank: one N x DW register bank with write enable, lane index, and flat N*DW read port. Instantiated once or twice.

## Test plan
- DW=8, N=8, samples 0x10..0x17 back to back, ACKo held 1 -> STBo at cycle 9 with DATo lane k = 0x10+k; ACKo accepted same cycle; ACKi never drops.
- Ping-pong, ACKo held 0, 24 samples offered -> ACKi = 1 for first 16 samples then 0; STBo = 1 with vector 0. First ACKo pulse -> DATo switches to vector 1 next cycle and ACKi = 1 again.
- Single-bank build, 16 samples continuous, ACKo pulsed 3 cycles after STBo -> ACKi low from cycle 9 until cycle after ACKo; second vector correct.
- SOFi after 3 samples (0xA0..0xA2) then 8 samples 0xB0..0xB7 with SOFi on 0xB0 -> single output vector 0xB0..0xB7, SYNC_ERRo = 1 and stays 1.
- RST for one cycle after 5 samples with one full vector pending -> STBo = 0, ACKi = STBi next cycle. Fresh 8 samples produce exactly one vector.
- DW=12, N=4 with random STBi gaps and ACKo backpressure -> scoreboard matches every vector in order, no loss or duplication.
